// File: rtl/cache_line_writer.sv
// Write-back engine: captures one cache line plus byte enables and writes it to BurstRAM as one write burst.
// Optional feature: define CACHE_LINE_WRITER_SKIP_EMPTY_EN so that requests with no byte enables finish without touching the RAM.
module cache_line_writer #(
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_COUNT    = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    localparam int LINE_BITWIDTH          = RAM_BURST_DATA_COUNT * RAM_BURST_DATA_BITWIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]          req_addr,
    input  logic [LINE_BITWIDTH-1:0]               req_data,
    input  logic [LINE_BITWIDTH/8-1:0]             req_be,
    output logic                                   done,
    output logic                                   br_cmd,
    output logic                                   br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]          br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]     br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0]   br_data_mask,
    input  logic                                   br_busy
);

    localparam int BEAT_BYTES = RAM_BURST_DATA_BITWIDTH / 8;
    localparam int OFF_W      = $clog2(RAM_BURST_DATA_COUNT);
    localparam int CNT_W      = (OFF_W > 0) ? OFF_W : 1;
    localparam logic [RAM_DEPTH_BITWIDTH-1:0] ALIGN_MASK = RAM_DEPTH_BITWIDTH'((1 << OFF_W) - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RAM_BURST_DATA_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BURST,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [RAM_BURST_DATA_COUNT-1:0][RAM_BURST_DATA_BITWIDTH-1:0] data_q;
    logic [RAM_BURST_DATA_COUNT-1:0][BEAT_BYTES-1:0]              be_q;
    logic [RAM_DEPTH_BITWIDTH-1:0] addr_q;
    logic [CNT_W-1:0]              beat_cnt_q, beat_cnt_d;
    logic                          done_q, done_d;
    logic                          accept;

    // The captured line is held for the whole burst so upstream is free once accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            be_q       <= '0;
            addr_q     <= '0;
            beat_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            done_q     <= done_d;
            if (accept) begin
                data_q <= req_data;
                be_q   <= req_be;
                addr_q <= req_addr & ~ALIGN_MASK;
            end
        end
    end

    assign br_addr = addr_q;
    assign done    = done_q;

    // done is registered, so req_ready is held low during the done cycle as well.
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        done_d       = 1'b0;
        accept       = 1'b0;
        req_ready    = 1'b0;
        br_cmd       = 1'b0;
        br_cmd_en    = 1'b0;
        br_wr_data   = '0;
        br_data_mask = '0;

        case (state_q)
            IDLE: begin
                req_ready = ~done_q;
                if (req_valid && !done_q) begin
                    accept = 1'b1;
`ifdef CACHE_LINE_WRITER_SKIP_EMPTY_EN
                    if (req_be == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
`else
                    state_d = ISSUE;
`endif
                end
            end

            ISSUE: begin
                if (!br_busy) begin
                    br_cmd_en    = 1'b1;
                    br_cmd       = 1'b1;
                    br_wr_data   = data_q[0];
                    br_data_mask = ~be_q[0];
                    beat_cnt_d   = CNT_W'(1);
                    state_d      = (RAM_BURST_DATA_COUNT == 1) ? DRAIN : BURST;
                end
            end

            BURST: begin
                br_wr_data   = data_q[beat_cnt_q];
                br_data_mask = ~be_q[beat_cnt_q];
                if (beat_cnt_q == LAST_BEAT) begin
                    state_d = DRAIN;
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end

            DRAIN: begin
                if (!br_busy) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/cache_line_writer.md
# cache_line_writer

Write-back engine that takes one full cache line plus byte enables from the cache and writes it into BurstRAM as a single write burst. It is the write-direction counterpart to the cache's line-fill path. It drives the same `br_` command/data interface, with `br_cmd = 1` (write) instead of `0` (read). It sits between the data cache's eviction/flush logic and the BurstRAM port arbiter.

## Interface
Parameters:
- `RAM_DEPTH_BITWIDTH`, 4: BurstRAM address width; the address unit is one `RAM_BURST_DATA_BITWIDTH` word.
- `RAM_BURST_DATA_COUNT`, 4: beats per burst; must be a power of two.
- `RAM_BURST_DATA_BITWIDTH`, 64: bits per beat; must be divisible by 8.
- `LINE_BITWIDTH`, derived: `RAM_BURST_DATA_COUNT * RAM_BURST_DATA_BITWIDTH` (256, i.e. 32 B).

Ports:
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: a line write is requested.
- `req_ready` out 1: writer is idle; a request is accepted when `req_valid & req_ready`.
- `req_addr` in `RAM_DEPTH_BITWIDTH`: word address of the line; its low `log2(RAM_BURST_DATA_COUNT)` bits are forced to 0.
- `req_data` in `LINE_BITWIDTH`: line data; beat k = `req_data[k*64 +: 64]`.
- `req_be` in `LINE_BITWIDTH/8`: byte enables, 1 = write the byte.
- `done` out 1: one-cycle pulse when the line write has completed.
- `br_cmd` out 1: always 1 while `br_cmd_en` is high.
- `br_cmd_en` out 1: command strobe.
- `br_addr` out `RAM_DEPTH_BITWIDTH`: burst start address.
- `br_wr_data` out `RAM_BURST_DATA_BITWIDTH`: current beat.
- `br_data_mask` out `RAM_BURST_DATA_BITWIDTH/8`: 1 = byte masked (not written), i.e. the inverse of the beat's `req_be` slice.
- `br_busy` in 1: BurstRAM is busy.

## Operation
- On accept, the writer captures `req_addr`, `req_data` and `req_be` into internal registers. Upstream may change its inputs afterwards.
- States:
  - IDLE: `req_ready=1`. On accept, go to ISSUE.
  - ISSUE: if `br_busy=1`, stay (the command is not issued). Otherwise drive `br_cmd_en=1`, `br_cmd=1`, `br_addr`, and beat 0 with its mask; beat counter := 1; go to BURST.
  - BURST: drive beat[counter] and its mask for one cycle each; `br_cmd_en=0`. After beat `RAM_BURST_DATA_COUNT-1`, go to DRAIN.
  - DRAIN: stay for at least one cycle. Leave on the first cycle that samples `br_busy=0`: pulse `done`, go to IDLE.
- `br_busy` is ignored in BURST; the RAM accepts beats back-to-back.
- `br_wr_data` and `br_data_mask` are 0 outside ISSUE and BURST. `br_addr` holds the captured address outside IDLE.
- The beat counter is `log2(RAM_BURST_DATA_COUNT)` bits wide and must not wrap before reaching DRAIN.

## Timing
- Reset values: `req_ready=1`, `done=0`, `br_cmd=0`, `br_cmd_en=0`, `br_addr=0`, `br_wr_data=0`, `br_data_mask=0`; state = IDLE.
- Accept at edge N. With `br_busy` low, `br_cmd_en` is high during cycle N+1 (beat 0), and beats 1–3 follow in N+2 to N+4.
- `done` rises no earlier than cycle N+6. `req_ready` returns to 1 in the cycle after `done`.
- `req_ready` is low from accept until after `done`. A `req_valid` held high through `done` is accepted at the edge after `done` (one idle cycle minimum between bursts).
- Reset mid-burst: all outputs go to their reset values immediately and the line is dropped. The system resets BurstRAM together with the writer.

## Configuration
- `CACHE_LINE_WRITER_SKIP_EMPTY_EN` defined: a request with `req_be` all zero is accepted, issues no RAM command, and pulses `done` in the cycle after accept.
- Not defined: every request issues a full burst, with all-ones `br_data_mask` when `req_be=0`.

## Test plan
- Full line write: addr=0, data words `0x1111…1111`–`0x4444…4444`, `req_be` all ones, `br_busy=0`. Expect `br_cmd_en` for one cycle, 4 beats in order with mask `8'h00`, `done` once. A cache read of addr 0 then returns `0x11111111` at byte address 0.
- Partial mask: `req_be` = `32'h0000_00F0`. Expect beat 0 mask `8'h0F` and beats 1–3 mask `8'hFF`; RAM changes only bytes 4–7 of word 0.
- Busy stall: hold `br_busy=1` for 5 cycles after accept. Expect `br_cmd_en=0` throughout and the command in the first cycle with `br_busy=0`; beats stay contiguous.
- Address alignment: `req_addr=4'b0111`. Expect `br_addr=4'b0100`.
- Async reset during beat 2: `br_cmd_en` and `br_data_mask` drop to 0 immediately, `req_ready=1` after reset, and no `done` pulse.
- Empty request (`req_be=0`), built both ways: with `CACHE_LINE_WRITER_SKIP_EMPTY_EN`, `done` in the cycle after accept and no `br_cmd_en`. Without it, a full burst with mask `8'hFF` on every beat and RAM contents unchanged.
